// File: rtl/mips_multictrl_ws.sv
// mips_multictrl_ws: multicycle MIPS controller (main FSM, ALU decoder, PC enable)
// with a memready handshake and a wait-state watchdog that parks in FAULT.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes enter a sticky TRAP
// state and raise the extra 'trap' output instead of being skipped as a NOP.

module mips_multictrl_ws #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memreq,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       alusrca,
  output logic       iord,
  output logic       extop,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       fault,
  output logic [3:0] state
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       trap
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    IMMEX   = 4'd9,
    IMMWB   = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12,
    JALEX   = 4'd13,
    FAULT   = 4'd14,
    TRAP    = 4'd15
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pcwrite, branch, branchne;

  // State and wait-counter registers; reset aborts any access and refetches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state selection; the counter only runs while a memory state waits.
  always_comb begin
    state_d = state_q;
    count_d = '0;
    case (state_q)
      FETCH, MEMRD, MEMWR: begin
        if (memready) begin
          case (state_q)
            FETCH:   state_d = DECODE;
            MEMRD:   state_d = MEMWB;
            default: state_d = FETCH;
          endcase
        end else if (count_q == WAIT_LIMIT) begin
          state_d = FAULT;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      DECODE: begin
        case (op)
          OP_LW, OP_SW:                        state_d = MEMADR;
          OP_RTYPE:                            state_d = RTYPEEX;
          OP_BEQ:                              state_d = BEQEX;
          OP_BNE:                              state_d = BNEEX;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:   state_d = IMMEX;
          OP_J:                                state_d = JEX;
          OP_JAL:                              state_d = JALEX;
`ifdef ILLEGAL_TRAP_EN
          default:                             state_d = TRAP;
`else
          default:                             state_d = FETCH;
`endif
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      RTYPEEX: state_d = RTYPEWB;
      IMMEX:   state_d = IMMWB;
      FAULT:   state_d = FAULT;
`ifdef ILLEGAL_TRAP_EN
      TRAP:    state_d = TRAP;
`endif
      default: state_d = FETCH;
    endcase
  end

  // Datapath controls decoded from the current state, with enables masked in reset.
  always_comb begin
    memreq     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    regdst     = 2'b00;
    memtoreg   = 2'b00;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_AND;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    fault      = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    trap       = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        memreq     = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite    = memready;
        pcwrite    = memready;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
      end
      MEMWR: begin
        memreq   = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 2'b01;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
      end
      BEQEX, BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = (state_q == BEQEX);
        branchne   = (state_q == BNEEX);
      end
      IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          OP_SLTI: alucontrol = ALU_SLT;
          OP_ANDI: alucontrol = ALU_AND;
          OP_ORI:  alucontrol = ALU_OR;
          default: alucontrol = ALU_ADD;
        endcase
      end
      IMMWB: regwrite = 1'b1;
      JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      JALEX: begin
        pcwrite  = 1'b1;
        pcsrc    = 2'b10;
        regwrite = 1'b1;
        regdst   = 2'b10;
        memtoreg = 2'b10;
      end
      FAULT: fault = 1'b1;
`ifdef ILLEGAL_TRAP_EN
      TRAP:  trap = 1'b1;
`endif
      default: ;
    endcase
    extop = (op == OP_ANDI) || (op == OP_ORI);
    pcen  = pcwrite | (branch & zero) | (branchne & ~zero);
    if (reset) begin
      memreq   = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      pcen     = 1'b0;
    end
  end

  assign state = state_q;

endmodule
